// File: rtl/lea_key_schedule_stream.sv
// LEA key-schedule engine: 128/192/256-bit keys, one 192-bit round key
// per cycle on a valid/ready stream, with start/busy/done/err control.
module lea_key_schedule_stream #(
  parameter int MAX_KEY_LEN = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [4:0]   rk_index,
  output logic [191:0] rk_data,
  output logic         rk_last
);

  localparam int NT = MAX_KEY_LEN / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DONE
  } state_t;

  state_t       state;
  logic [31:0]  t    [NT];
  logic [31:0]  t_nx [NT];
  logic [1:0]   mode_q;
  logic [5:0]   rnd;
  logic [5:0]   nr;
  logic [31:0]  d;
  logic [191:0] rk_nx;
  logic         legal;
  logic [2:0]   m;

  function automatic logic [31:0] rol(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    logic [63:0] w;
    w = {x, x} << n;
    return w[63:32];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] delta(input logic [2:0] k);
    logic [31:0] v;
    unique case (k)
      3'd0: v = 32'hc3efe9db;
      3'd1: v = 32'h44626b02;
      3'd2: v = 32'h79e27c8a;
      3'd3: v = 32'h78df30ec;
      3'd4: v = 32'h715ea49e;
      3'd5: v = 32'hc785da0a;
      3'd6: v = 32'he04ef22a;
      default: v = 32'he5c40957;
    endcase
    return v;
  endfunction

  function automatic logic [4:0] rot_amt(input int j);
    logic [4:0] v;
    unique case (j)
      0: v = 5'd1;
      1: v = 5'd3;
      2: v = 5'd6;
      3: v = 5'd11;
      4: v = 5'd13;
      default: v = 5'd17;
    endcase
    return v;
  endfunction

  // Key length legality against the build-time maximum
  always_comb begin
    unique case (mode)
      2'b00: legal = 1'b1;
      2'b01: legal = (MAX_KEY_LEN >= 192);
      2'b10: legal = (MAX_KEY_LEN >= 256);
      default: legal = 1'b0;
    endcase
  end

  // Round count for the latched key length
  always_comb begin
    unique case (mode_q)
      2'b01: nr = 6'd28;
      2'b10: nr = 6'd32;
      default: nr = 6'd24;
    endcase
  end

  // One key-schedule round: next T values and the round key built from them
  always_comb begin
    for (int k = 0; k < NT; k++) t_nx[k] = t[k];
    rk_nx = '0;
    d     = '0;
    m     = '0;
    unique case (mode_q)
      2'b01: begin
        d = delta(3'(rnd % 6));
        for (int j = 0; j < 6; j++) begin
          t_nx[j % NT] = rol(t[j % NT] + rol(d, rnd[4:0] + 5'(j)),
                             rot_amt(j));
          rk_nx[191-32*j -: 32] = t_nx[j % NT];
        end
      end
      2'b10: begin
        d = delta(rnd[2:0]);
        for (int j = 0; j < 6; j++) begin
          m = 3'(rnd * 6 + j);
          t_nx[m % NT] = rol(t[m % NT] + rol(d, rnd[4:0] + 5'(j)),
                             rot_amt(j));
          rk_nx[191-32*j -: 32] = t_nx[m % NT];
        end
      end
      default: begin
        d = delta({1'b0, rnd[1:0]});
        for (int j = 0; j < 4; j++) begin
          t_nx[j % NT] = rol(t[j % NT] + rol(d, rnd[4:0] + 5'(j)),
                             rot_amt(j));
        end
        rk_nx = {t_nx[0], t_nx[1], t_nx[2 % NT],
                 t_nx[1], t_nx[3 % NT], t_nx[1]};
      end
    endcase
  end

  // Control FSM, T register file and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk_index <= '0;
      rk_data  <= '0;
      rk_last  <= 1'b0;
      mode_q   <= '0;
      rnd      <= '0;
      for (int k = 0; k < NT; k++) t[k] <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && legal) begin
            for (int k = 0; k < NT; k++)
              t[k] <= bswap(key[255-32*k -: 32]);
            mode_q <= mode;
            rnd    <= '0;
            busy   <= 1'b1;
            state  <= S_GEN;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        S_GEN: begin
          if (rk_valid && rk_ready && rk_last) begin
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if ((!rk_valid || rk_ready) && rnd < nr) begin
            for (int k = 0; k < NT; k++) t[k] <= t_nx[k];
            rk_data  <= rk_nx;
            rk_index <= rnd[4:0];
            rk_last  <= (rnd == nr - 6'd1);
            rk_valid <= 1'b1;
            rnd      <= rnd + 6'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
